// File: rtl/dram_arbiter.sv
// dram_arbiter: two-requester round-robin arbiter onto an AXI-lite DRAM master port
module dram_arbiter #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [1:0]        rw,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              AR_VALID,
  output logic [ADDR_W-1:0] AR_ADDR,
  input  logic              AR_READY,
  input  logic              R_VALID,
  input  logic [DATA_W-1:0] R_DATA,
  input  logic [1:0]        R_RESP,
  output logic              R_READY,
  output logic              AW_VALID,
  output logic [ADDR_W-1:0] AW_ADDR,
  input  logic              AW_READY,
  output logic              W_VALID,
  output logic [DATA_W-1:0] W_DATA,
  input  logic              W_READY,
  input  logic              B_VALID,
  input  logic [1:0]        B_RESP,
  output logic              B_READY
);
  typedef enum logic [2:0] {IDLE, AR, R, AW, W, B, DONE} stateT;
  stateT state;
  logic grant, lastServed, pick;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] wdataQ;
  assign pick = (req == 2'b11) ? ~lastServed : req[1];
  assign AR_ADDR = addrQ;
  assign AW_ADDR = addrQ;
  assign W_DATA = wdataQ;
  // Transaction FSM: grant, run the DRAM handshakes, capture the response, pulse done
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= 1'b0;
      lastServed <= 1'b1;
      addrQ <= '0;
      wdataQ <= '0;
      done <= 2'b00;
      rdata <= '0;
      err <= 1'b0;
      AR_VALID <= 1'b0;
      R_READY <= 1'b0;
      AW_VALID <= 1'b0;
      W_VALID <= 1'b0;
      B_READY <= 1'b0;
    end else begin
      done <= 2'b00;
      case (state)
        IDLE: if (|req) begin
          grant <= pick;
          addrQ <= pick ? addr1 : addr0;
          wdataQ <= pick ? wdata1 : wdata0;
          state <= rw[pick] ? AW : AR;
          AW_VALID <= rw[pick];
          AR_VALID <= ~rw[pick];
        end
        AR: if (AR_READY) begin
          AR_VALID <= 1'b0;
          R_READY <= 1'b1;
          state <= R;
        end
        R: if (R_VALID) begin
          R_READY <= 1'b0;
          rdata <= R_DATA;
          err <= |R_RESP;
          state <= DONE;
        end
        AW: if (AW_READY) begin
          AW_VALID <= 1'b0;
          W_VALID <= 1'b1;
          state <= W;
        end
        W: if (W_READY) begin
          W_VALID <= 1'b0;
          B_READY <= 1'b1;
          state <= B;
        end
        B: if (B_VALID) begin
          B_READY <= 1'b0;
          err <= |B_RESP;
          state <= DONE;
        end
        DONE: begin
          done <= grant ? 2'b10 : 2'b01;
          lastServed <= grant;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: transaction-level model of the arbiter against directed and random traffic
module tb_dram_arbiter;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 64;

  logic clk, rst;
  logic [1:0] req, rw, done, R_RESP, B_RESP;
  logic [ADDR_W-1:0] addr0, addr1, AR_ADDR, AW_ADDR;
  logic [DATA_W-1:0] wdata0, wdata1, rdata, R_DATA, W_DATA;
  logic err, AR_VALID, AR_READY, R_VALID, R_READY, AW_VALID, AW_READY;
  logic W_VALID, W_READY, B_VALID, B_READY;

  dram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .req(req), .rw(rw), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .done(done), .rdata(rdata), .err(err),
    .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .AR_READY(AR_READY),
    .R_VALID(R_VALID), .R_DATA(R_DATA), .R_RESP(R_RESP), .R_READY(R_READY),
    .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .AW_READY(AW_READY),
    .W_VALID(W_VALID), .W_DATA(W_DATA), .W_READY(W_READY),
    .B_VALID(B_VALID), .B_RESP(B_RESP), .B_READY(B_READY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nVec, nMis, cycle, cd, txCount, busyCyc, arCnt, lastLat, lastArCnt, arHold, repeatLeft, tStart;
  int grantLog[256];
  logic busy, owner, lastServed, grantJust, arDone, awDone, wDone, rvDrv, bvDrv, mErr;
  logic prevArV, prevArR, prevAwV, prevAwR, prevWV, prevWR, rstPrev, rstK;
  logic slaveRand, randReq, dropMode, randRst, wBlock;
  logic [1:0] pending, pRw, respKnob, lastDone;
  logic [ADDR_W-1:0] pAddr[2];
  logic [ADDR_W-1:0] seenArAddr, seenAwAddr;
  logic [DATA_W-1:0] pData[2];
  logic [DATA_W-1:0] mRdata, rdataKnob, seenWData;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    nVec++;
    if (act !== want) begin
      nMis++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, want, cycle);
    end
  endtask

  task automatic issue(input int i, input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    pending[i] = 1'b1;
    pRw[i] = w;
    pAddr[i] = a;
    pData[i] = d;
  endtask

  // One clock: check what the DUT shows after the last edge, advance the model, drive the next edge
  task automatic step();
    logic [1:0] expDone;
    @(negedge clk);
    cycle++;
    if (rstPrev) begin
      chk("rstCtl", 64'({done, err, AR_VALID, R_READY, AW_VALID, W_VALID, B_READY}), 64'd0);
      chk("rstRdata", rdata, 64'd0);
      chk("rstAddr", 64'({AR_ADDR, AW_ADDR}), 64'd0);
      chk("rstWdata", W_DATA, 64'd0);
      busy = 1'b0; lastServed = 1'b1; cd = -1; pending = 2'b00;
      rvDrv = 1'b0; bvDrv = 1'b0; mRdata = '0; mErr = 1'b0;
    end else begin
      if (prevArV && prevArR) arDone = 1'b1;
      if (prevAwV && prevAwR) awDone = 1'b1;
      if (prevWV && prevWR) wDone = 1'b1;
      if (cd > 0) cd--;
      expDone = (cd == 0) ? (owner ? 2'b10 : 2'b01) : 2'b00;
      chk("done", 64'(done), 64'(expDone));
      if (cd == 0) begin
        lastLat = cycle - tStart;
        lastDone = done;
        lastArCnt = arCnt;
        if (txCount < 256) grantLog[txCount] = int'(owner);
        txCount++;
        lastServed = owner;
        busy = 1'b0;
        cd = -1;
        if (repeatLeft > 0) repeatLeft--;
        else pending[owner] = 1'b0;
      end
      chk("rdata", rdata, mRdata);
      chk("err", 64'(err), 64'(mErr));
      if (!busy) chk("idleHs", 64'({AR_VALID, R_READY, AW_VALID, W_VALID, B_READY}), 64'd0);
      else begin
        busyCyc++;
        if (AR_VALID) begin arCnt++; seenArAddr = AR_ADDR; end
        if (AW_VALID) seenAwAddr = AW_ADDR;
        if (W_VALID) seenWData = W_DATA;
        if (cd == 1) chk("respRdyDrop", 64'({R_READY, B_READY}), 64'd0);
        if (!pRw[owner]) begin
          chk("rdNoWrite", 64'({AW_VALID, W_VALID, B_READY}), 64'd0);
          if (AR_VALID) chk("arAddr", 64'(AR_ADDR), 64'(pAddr[owner]));
          if (grantJust) chk("arStart", 64'(AR_VALID), 64'd1);
          if (prevArV && !prevArR) chk("arHold", 64'(AR_VALID), 64'd1);
          if (arDone) chk("arAfter", 64'(AR_VALID), 64'd0);
          else chk("rEarly", 64'(R_READY), 64'd0);
        end else begin
          chk("wrNoRead", 64'({AR_VALID, R_READY}), 64'd0);
          chk("awwOverlap", 64'(AW_VALID && W_VALID), 64'd0);
          if (AW_VALID) chk("awAddr", 64'(AW_ADDR), 64'(pAddr[owner]));
          if (W_VALID) chk("wData", W_DATA, pData[owner]);
          if (grantJust) chk("awStart", 64'(AW_VALID), 64'd1);
          if (prevAwV && !prevAwR) chk("awHold", 64'(AW_VALID), 64'd1);
          if (prevWV && !prevWR) chk("wHold", 64'(W_VALID), 64'd1);
          if (awDone) chk("awAfter", 64'(AW_VALID), 64'd0);
          else chk("wEarly", 64'(W_VALID), 64'd0);
          if (wDone) chk("wAfter", 64'(W_VALID), 64'd0);
          else chk("bEarly", 64'(B_READY), 64'd0);
        end
        if (busyCyc > 200) begin
          nMis++;
          $display("FAIL watchdog: transaction still open after %0d cycles, required done", busyCyc);
          $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
          $fatal(1, "transaction never completed");
        end
      end
    end
    grantJust = 1'b0;
    rst = rstK | (randRst && $urandom_range(299) == 0);
    AR_READY = slaveRand ? ($urandom_range(2) == 0) : (arCnt >= arHold);
    AW_READY = slaveRand ? ($urandom_range(2) == 0) : 1'b1;
    W_READY = slaveRand ? ($urandom_range(2) == 0) : !wBlock;
    if (rvDrv) rvDrv = 1'b0;
    else if (R_READY && (!slaveRand || $urandom_range(1) == 0)) begin
      rvDrv = 1'b1;
      R_DATA = slaveRand ? {$urandom, $urandom} : rdataKnob;
      R_RESP = slaveRand ? 2'($urandom) : respKnob;
      mRdata = R_DATA;
      mErr = R_RESP != 2'b00;
      cd = 2;
    end
    R_VALID = rvDrv;
    if (bvDrv) bvDrv = 1'b0;
    else if (B_READY && (!slaveRand || $urandom_range(1) == 0)) begin
      bvDrv = 1'b1;
      B_RESP = slaveRand ? 2'($urandom) : respKnob;
      mErr = B_RESP != 2'b00;
      cd = 2;
    end
    B_VALID = bvDrv;
    for (int i = 0; i < 2; i++) begin
      if (!pending[i] && randReq && $urandom_range(3) == 0)
        issue(i, 1'($urandom), ADDR_W'($urandom), {$urandom, $urandom});
      req[i] = (busy && int'(owner) == i && dropMode) ? 1'($urandom) : pending[i];
    end
    rw = pRw;
    addr0 = pAddr[0]; addr1 = pAddr[1];
    wdata0 = pData[0]; wdata1 = pData[1];
    if (!busy && !rst && req != 2'b00) begin
      owner = (req == 2'b11) ? !lastServed : req[1];
      busy = 1'b1; grantJust = 1'b1;
      arDone = 1'b0; awDone = 1'b0; wDone = 1'b0;
      arCnt = 0; busyCyc = 0; tStart = cycle;
    end
    prevArV = AR_VALID; prevArR = AR_READY;
    prevAwV = AW_VALID; prevAwR = AW_READY;
    prevWV = W_VALID; prevWR = W_READY;
    rstPrev = rst;
  endtask

  task automatic waitTx(input int n);
    int target;
    target = txCount + n;
    for (int k = 0; k < 300 && txCount < target; k++) step();
    chk("txCount", 64'(txCount), 64'(target));
  endtask

  initial begin
    int base;
    nVec = 0; nMis = 0; cycle = 0; cd = -1; txCount = 0; busyCyc = 0; arCnt = 0;
    lastLat = 0; lastArCnt = 0; arHold = 0; repeatLeft = 0; tStart = 0;
    busy = 0; owner = 0; lastServed = 1; grantJust = 0; arDone = 0; awDone = 0; wDone = 0;
    rvDrv = 0; bvDrv = 0; mErr = 0; mRdata = '0; lastDone = 0;
    prevArV = 0; prevArR = 0; prevAwV = 0; prevAwR = 0; prevWV = 0; prevWR = 0;
    slaveRand = 0; randReq = 0; dropMode = 0; randRst = 0; wBlock = 0;
    pending = 0; pRw = 0; respKnob = 0; rdataKnob = '0;
    pAddr[0] = '0; pAddr[1] = '0; pData[0] = '0; pData[1] = '0;
    seenArAddr = '0; seenAwAddr = '0; seenWData = '0;
    req = 0; rw = 0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    AR_READY = 0; R_VALID = 0; R_DATA = '0; R_RESP = 0;
    AW_READY = 0; W_READY = 0; B_VALID = 0; B_RESP = 0;
    rst = 1; rstK = 1; rstPrev = 1;
    repeat (3) step();
    rstK = 0;
    step();

    rdataKnob = 64'h1122334455667788;
    issue(0, 1'b0, 17'h10008, 64'd0);
    waitTx(1);
    chk("rdLatency", 64'(lastLat), 64'd4);
    chk("rdDone", 64'(lastDone), 64'd1);
    chk("rdData", rdata, 64'h1122334455667788);
    chk("rdErr", 64'(err), 64'd0);
    chk("rdArAddr", 64'(seenArAddr), 64'h10008);

    issue(1, 1'b1, 17'h107F8, 64'hDEADBEEF00000001);
    waitTx(1);
    chk("wrLatency", 64'(lastLat), 64'd5);
    chk("wrDone", 64'(lastDone), 64'd2);
    chk("wrErr", 64'(err), 64'd0);
    chk("wrAwAddr", 64'(seenAwAddr), 64'h107F8);
    chk("wrWData", seenWData, 64'hDEADBEEF00000001);

    rstK = 1; step(); rstK = 0; step();
    base = txCount;
    issue(0, 1'b0, 17'h00A00, 64'd0);
    issue(1, 1'b0, 17'h00B00, 64'd0);
    repeatLeft = 2;
    waitTx(4);
    chk("rr0", 64'(grantLog[base]), 64'd0);
    chk("rr1", 64'(grantLog[base+1]), 64'd1);
    chk("rr2", 64'(grantLog[base+2]), 64'd0);
    chk("rr3", 64'(grantLog[base+3]), 64'd1);

    arHold = 6;
    issue(0, 1'b0, 17'h00040, 64'd0);
    waitTx(1);
    chk("arStallCycles", 64'(lastArCnt), 64'd6);
    chk("bpDone", 64'(lastDone), 64'd1);
    arHold = 0;
    base = txCount;
    repeat (4) step();
    chk("bpSingleDone", 64'(txCount), 64'(base));

    respKnob = 2'b10;
    issue(0, 1'b1, 17'h1FFF8, 64'h5555AAAA5555AAAA);
    waitTx(1);
    chk("bErr", 64'(err), 64'd1);
    chk("bErrDone", 64'(lastDone), 64'd1);
    respKnob = 2'b00;

    wBlock = 1;
    issue(1, 1'b1, 17'h00100, 64'hA5A5A5A5A5A5A5A5);
    for (int k = 0; k < 20 && !W_VALID; k++) step();
    chk("reachedW", 64'(W_VALID), 64'd1);
    base = txCount;
    rstK = 1; step(); rstK = 0; step();
    wBlock = 0;
    repeat (3) step();
    chk("rstNoDone", 64'(txCount), 64'(base));
    issue(0, 1'b0, 17'h00200, 64'd0);
    issue(1, 1'b0, 17'h00300, 64'd0);
    waitTx(2);
    chk("postRstFirst", 64'(grantLog[base]), 64'd0);
    chk("postRstSecond", 64'(grantLog[base+1]), 64'd1);

    slaveRand = 1; randReq = 1; dropMode = 1; randRst = 1;
    repeat (4000) step();
    randReq = 0; randRst = 0;
    for (int k = 0; k < 600 && (busy || pending != 2'b00); k++) step();
    chk("drain", 64'({busy, pending}), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end
endmodule
